// File: rtl/mistral_lut_cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mistral_lut_cfg_ctrl_pkg : shared constants, state encoding and width helpers
// Revision : 1.0
// ============================================================================
package mistral_lut_cfg_ctrl_pkg;

    localparam int LUT_BITS   = 64;
    localparam int LUT_INPUTS = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single LUT still gets a 1-bit select so that out-of-range indices exist.
    function automatic int sel_width(input int num_luts);
        return (num_luts > 1) ? clog2(num_luts) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mistral_lut_cfg_ctrl_lut6_shadow.sv
`default_nettype none
// ============================================================================
// mistral_lut6_shadow : one LUT6 cell, active mask replaced atomically on commit
// Revision : 1.0
// ============================================================================
module mistral_lut6_shadow
    import mistral_lut_cfg_ctrl_pkg::*;
#(
    parameter logic [LUT_BITS-1:0] INIT_MASK = '0
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic                  commit,
    input  logic [LUT_BITS-1:0]   data,
    input  logic [LUT_INPUTS-1:0] addr,
    output logic                  q
);

    logic [LUT_BITS-1:0] active;

    always_ff @(posedge clk) begin
        if (sclr) begin
            active <= INIT_MASK;
        end else if (commit) begin
            active <= data;
        end
    end

    assign q = active[addr];

endmodule
`default_nettype wire

// File: rtl/mistral_lut_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// mistral_lut_cfg_ctrl : serial mask loader with atomic commit into a LUT6 bank
// Revision : 1.0
// ============================================================================
module mistral_lut_cfg_ctrl
    import mistral_lut_cfg_ctrl_pkg::*;
#(
    parameter int                  NUM_LUTS  = 4,
    parameter int                  SHIFT_W   = 8,
    parameter logic [LUT_BITS-1:0] INIT_MASK = 64'h0
) (
    input  logic                               clk,
    input  logic                               sclr,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [sel_width(NUM_LUTS)-1:0]     cfg_sel,
    input  logic [LUT_BITS-1:0]                cfg_mask,
    output logic                               cfg_done,
    output logic                               busy,
    input  logic [LUT_INPUTS*NUM_LUTS-1:0]     addr,
    output logic [NUM_LUTS-1:0]                q
);

    localparam int K     = LUT_BITS / SHIFT_W;
    localparam int CNT_W = clog2(K) + 1;
    localparam int SEL_W = sel_width(NUM_LUTS);

    cfg_state_t          state;
    cfg_state_t          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [LUT_BITS-1:0] mask_lat;
    logic [LUT_BITS-1:0] shadow;
    logic [LUT_BITS-1:0] shadow_nxt;
    logic [SEL_W-1:0]    sel_lat;
    logic [SHIFT_W-1:0]  chunk;
    logic                accept;
    logic                shift_en;
    logic                commit;
    logic                done_q;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SHIFT dwells one extra cycle with cnt==K before handing over to COMMIT.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(K)) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    shift_en = 1'b1;
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        chunk = '0;
        for (int i = 0; i < K; i++) begin
            if (cnt == CNT_W'(i)) begin
                chunk = mask_lat[i*SHIFT_W +: SHIFT_W];
            end
        end
    end

    if (SHIFT_W == LUT_BITS) begin : g_shift_full
        assign shadow_nxt = chunk;
    end else begin : g_shift_part
        assign shadow_nxt = {chunk, shadow[LUT_BITS-1:SHIFT_W]};
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt      <= '0;
            mask_lat <= '0;
            sel_lat  <= '0;
            shadow   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= commit;
            if (accept) begin
                mask_lat <= cfg_mask;
                sel_lat  <= cfg_sel;
                cnt      <= '0;
            end else if (shift_en) begin
                shadow <= shadow_nxt;
                cnt    <= cnt + 1'b1;
            end else if (state == ST_SHIFT) begin
                cnt <= '0;
            end
        end
    end

    assign cfg_done = done_q;
    assign busy     = ~cfg_ready;

    // An index beyond the bank matches no cell, so the commit is simply dropped.
    for (genvar k = 0; k < NUM_LUTS; k++) begin : g_lut
        logic commit_k;
        assign commit_k = commit && (sel_lat == SEL_W'(k));

        mistral_lut6_shadow #(
            .INIT_MASK (INIT_MASK)
        ) u_lut (
            .clk    (clk),
            .sclr   (sclr),
            .commit (commit_k),
            .data   (shadow),
            .addr   (addr[LUT_INPUTS*k +: LUT_INPUTS]),
            .q      (q[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_mistral_lut_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mistral_lut_cfg_ctrl : scoreboard bench, random traffic plus edge configs
// Revision : 1.0
// ============================================================================
module tb_mistral_lut_cfg_ctrl;

    localparam int          NL    = 4;
    localparam int          K     = 8;
    localparam logic [63:0] INIT  = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] INIT2 = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sclr, cfg_valid, cfg_ready, cfg_done, busy;
    logic [1:0]  cfg_sel;
    logic [63:0] cfg_mask;
    logic [23:0] addr;
    logic [3:0]  q;

    mistral_lut_cfg_ctrl #(.NUM_LUTS(NL), .SHIFT_W(8), .INIT_MASK(INIT)) dut (
        .clk(clk), .sclr(sclr), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_mask(cfg_mask), .cfg_done(cfg_done), .busy(busy),
        .addr(addr), .q(q)
    );

    logic        e64_sclr, e64_valid, e64_ready, e64_done, e64_busy;
    logic [1:0]  e64_sel;
    logic [63:0] e64_mask;
    logic [17:0] e64_addr;
    logic [2:0]  e64_q;

    mistral_lut_cfg_ctrl #(.NUM_LUTS(3), .SHIFT_W(64), .INIT_MASK(INIT2)) dut_w64 (
        .clk(clk), .sclr(e64_sclr), .cfg_valid(e64_valid), .cfg_ready(e64_ready),
        .cfg_sel(e64_sel), .cfg_mask(e64_mask), .cfg_done(e64_done), .busy(e64_busy),
        .addr(e64_addr), .q(e64_q)
    );

    logic        e1_sclr, e1_valid, e1_ready, e1_done, e1_busy;
    logic [1:0]  e1_sel;
    logic [63:0] e1_mask;
    logic [23:0] e1_addr;
    logic [3:0]  e1_q;

    mistral_lut_cfg_ctrl #(.NUM_LUTS(4), .SHIFT_W(1), .INIT_MASK(INIT)) dut_w1 (
        .clk(clk), .sclr(e1_sclr), .cfg_valid(e1_valid), .cfg_ready(e1_ready),
        .cfg_sel(e1_sel), .cfg_mask(e1_mask), .cfg_done(e1_done), .busy(e1_busy),
        .addr(e1_addr), .q(e1_q)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] mask;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] model [NL];
    int          cyc      = 0;
    int          busy_end = 0;
    bit          started  = 0;
    logic [63:0] m64 [3];
    logic [63:0] m1  [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] rand_addr();
        logic [23:0] a;
        for (int k = 0; k < NL; k++) begin
            case ($urandom_range(0, 3))
                0:       a[6*k +: 6] = 6'd0;
                1:       a[6*k +: 6] = 6'd63;
                default: a[6*k +: 6] = 6'($urandom);
            endcase
        end
        return a;
    endfunction

    // One clock of stimulus; the reference model decides acceptance from its own
    // notion of when the controller is free (accept at n -> live and DONE at n+K+2).
    task automatic step(input bit v, input int sel, input logic [63:0] m, input bit rst,
                        output bit acc);
        sclr      = rst;
        cfg_valid = v;
        cfg_sel   = 2'(sel);
        cfg_mask  = m;
        addr      = rand_addr();
        @(posedge clk);
        cyc++;
        acc = 1'b0;
        if (rst) begin
            sbq.delete();
            for (int k = 0; k < NL; k++) model[k] = INIT;
            busy_end = cyc;
            started  = 1'b1;
        end else if (v && (cyc - 1 >= busy_end)) begin
            acc = 1'b1;
            sbq.push_back('{cyc + K + 2, sel, m});
            busy_end = cyc + K + 2;
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 0, {$urandom, $urandom}, 1'b0, a);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (started) begin
                bit   exp_done;
                exp_t e;
                chk("ready", 64'(cfg_ready), 64'(cyc >= busy_end));
                chk("busy", 64'(busy), 64'(cyc < busy_end));
                exp_done = (sbq.size() > 0) && (sbq[0].cyc == cyc);
                chk("done", 64'(cfg_done), 64'(exp_done));
                if (exp_done) begin
                    e = sbq.pop_front();
                    if (e.sel < NL) model[e.sel] = e.mask;
                end
                for (int k = 0; k < NL; k++) begin
                    logic [5:0] a;
                    a = addr[6*k +: 6];
                    chk($sformatf("q%0d", k), 64'(q[k]), 64'(model[k][a]));
                end
            end
        end
    end

    task automatic run_w64(input int s, input logic [63:0] m);
        int n;
        e64_sel   = 2'(s);
        e64_mask  = m;
        e64_valid = 1'b1;
        chk("w64_ready", 64'(e64_ready), 64'd1);
        @(posedge clk); #1;
        e64_valid = 1'b0;
        e64_mask  = ~m;
        e64_sel   = 2'd0;
        n = 0;
        while (!e64_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w64_latency", 64'(n), 64'd3);
        if (s < 3) m64[s] = m;
        @(posedge clk); #1;
        chk("w64_done_width", 64'(e64_done), 64'd0);
        for (int i = 0; i < 64; i++) begin
            e64_addr = {3{6'(i)}};
            #1;
            for (int k = 0; k < 3; k++) chk($sformatf("w64_q%0d", k), 64'(e64_q[k]), 64'(m64[k][i]));
        end
    endtask

    task automatic run_w1(input int s, input logic [63:0] m);
        int n;
        e1_sel   = 2'(s);
        e1_mask  = m;
        e1_valid = 1'b1;
        @(posedge clk); #1;
        e1_valid = 1'b0;
        e1_mask  = ~m;
        n = 0;
        while (!e1_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w1_latency", 64'(n), 64'd66);
        m1[s] = m;
        for (int i = 0; i < 64; i++) begin
            e1_addr = {4{6'(i)}};
            #1;
            for (int k = 0; k < 4; k++) chk($sformatf("w1_q%0d", k), 64'(e1_q[k]), 64'(m1[k][i]));
        end
    endtask

    initial begin : driver
        bit          a;
        int          guard;
        logic [63:0] m;
        e64_sclr = 1'b1; e64_valid = 1'b0; e64_sel = '0; e64_mask = '0; e64_addr = '0;
        e1_sclr  = 1'b1; e1_valid  = 1'b0; e1_sel  = '0; e1_mask  = '0; e1_addr  = '0;

        step(1'b0, 0, 64'd0, 1'b1, a);
        step(1'b1, 1, 64'd5, 1'b1, a);
        idle(4);

        step(1'b1, 2, 64'h8000_0000_0000_0001, 1'b0, a);
        idle(14);

        step(1'b1, 1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, a);
        idle(14);

        // Requests held valid: the second one must wait out the whole first load.
        m = {$urandom, $urandom};
        guard = 0;
        do begin step(1'b1, 0, m, 1'b0, a); guard++; end while (!a && guard < 30);
        m = {$urandom, $urandom};
        guard = 0;
        do begin step(1'b1, 3, m, 1'b0, a); guard++; end while (!a && guard < 30);
        idle(14);

        step(1'b1, 2, {$urandom, $urandom}, 1'b0, a);
        for (int i = 0; i < 3; i++) step(1'b1, 1, {$urandom, $urandom}, 1'b0, a);
        step(1'b1, 1, {$urandom, $urandom}, 1'b1, a);
        idle(14);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), {$urandom, $urandom},
                 $urandom_range(0, 99) == 0, a);
        end
        idle(15);
        chk("drain", 64'(sbq.size()), 64'd0);

        e64_sclr = 1'b0;
        e1_sclr  = 1'b0;
        for (int k = 0; k < 3; k++) m64[k] = INIT2;
        for (int k = 0; k < 4; k++) m1[k]  = INIT;
        run_w64(1, {$urandom, $urandom});
        run_w64(3, {$urandom, $urandom});
        run_w1(2, {$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
